alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of operands and result.
REQ-002 SHALL have parameter OPW, default 3, opcode width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  request can be accepted.
REQ-007 SHALL have ports req_op  input  OPW, req_a  input  WIDTH, and req_b  input  WIDTH, carrying the request opcode and operands.
REQ-008 SHALL have ports alu_opcode  output  OPW, alu_a  output  WIDTH, and alu_b  output  WIDTH, which drive the combinational ALU.
REQ-009 SHALL have ports alu_out  input  WIDTH, alu_cy  input  1, and alu_zero  input  1, the ALU results.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have ports rsp_data  output  WIDTH, rsp_cy  output  1, and rsp_zero  output  1, the captured result and flags.
REQ-013 SHALL have port busy  output  1, high in any state other than IDLE.
REQ-014 SHALL have port op_count  output  8, the count of completed responses.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: req_ready=1; on req_valid=1 at an edge, SHALL latch req_op/req_a/req_b into alu_opcode/alu_a/alu_b and go to ISSUE.
REQ-017 ISSUE: req_ready=0; SHALL hold ALU drive stable for exactly one cycle, then at the edge capture alu_out->rsp_data, alu_cy->rsp_cy, alu_zero->rsp_zero and go to RESP.
REQ-018 RESP: rsp_valid=1; rsp_data/rsp_cy/rsp_zero SHALL stay stable until rsp_valid&rsp_ready at an edge, then go to IDLE and increment op_count.
REQ-019 Latency: a request accepted at edge N SHALL give rsp_valid=1 from edge N+2; with rsp_ready held 1, the next request SHALL be accepted at edge N+3 at the earliest (one op per 3 cycles).
REQ-020 req_ready SHALL be 0 in ISSUE and RESP; req_valid in those states SHALL be ignored, not queued.
REQ-021 alu_opcode/alu_a/alu_b SHALL keep their last values in IDLE and RESP; they SHALL change only on acceptance.
REQ-022 rsp_data/rsp_cy/rsp_zero SHALL keep their last captured values after the handshake; only rsp_valid qualifies them.
REQ-023 All OPW-bit opcodes are legal; the block SHALL pass them through unmodified and SHALL not interpret the flags.
REQ-024 op_count SHALL wrap from 255 to 0.
REQ-025 rsp_ready=1 while rsp_valid=0 SHALL have no effect.

Reset
REQ-026 When rst_n=0 at an edge, the block SHALL enter IDLE regardless of state, abandoning any in-flight op with no response.
REQ-027 Reset values SHALL be: req_ready=1 (from the first post-reset cycle), rsp_valid=0, busy=0, op_count=0, and alu_opcode, alu_a, alu_b, rsp_data, rsp_cy, rsp_zero all 0.

Configuration
REQ-028 Macro ALU_SEQ_CHAIN_EN SHALL control operand chaining.
REQ-029 With ALU_SEQ_CHAIN_EN defined, the block SHALL add port req_chain  input  1; when it is 1 at acceptance, alu_a SHALL take the last captured rsp_data instead of req_a, which is 0 after reset.
REQ-030 Without ALU_SEQ_CHAIN_EN, the block SHALL not have port req_chain, and alu_a SHALL always take req_a.

Verification
REQ-031 Add: req op=0, A=0xF0, B=0x20, model ALU -> rsp_data=0x10, rsp_cy=1, rsp_zero=0, rsp_valid at acceptance+2.
REQ-032 Sub: op=1, A=0x05, B=0x05 -> rsp_data=0x00, rsp_cy=0, rsp_zero=1; then op=1, A=0x03, B=0x05 -> 0xFE, rsp_cy=1, rsp_zero=0.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/flags stable, req_ready=0, a req_valid pulse is ignored, and op_count increments once only after rsp_ready=1.
REQ-034 Reset mid-op: rst_n=0 during ISSUE -> next cycle IDLE, rsp_valid=0, op_count=0, and no response is ever produced.
REQ-035 Wrap: 256 back-to-back ops -> op_count returns to 0, with throughput of one op per 3 cycles.
REQ-036 Chain (ALU_SEQ_CHAIN_EN): op=0, A=0x01, B=0x01 -> 0x02; then chain=1, op=7, A=0xFF, B=0x01 -> alu_a=0x02, rsp_data=0x04.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- sequencer that feeds one request at a time to an external
// combinational ALU and returns the captured result on a response channel.
//
// Flow: IDLE accepts a request and registers the opcode/operands onto the ALU
// drive ports. ISSUE holds that drive for one full cycle, then captures the
// ALU result and flags. RESP presents the captured result until it is taken.
// With rsp_ready held high, one operation completes every three cycles.
//
// Handshake rule (both channels): a transfer happens at a rising clk edge
// where valid and ready are both 1. valid never depends on ready. Requests
// offered while req_ready=0 are ignored, not queued. rsp_ready while
// rsp_valid=0 has no effect.
//
// Optional feature, selected by the macro ALU_SEQ_CHAIN_EN:
//   adds input req_chain. When it is 1 at acceptance, alu_a is loaded from the
//   last captured rsp_data instead of req_a. Without the macro, alu_a always
//   loads req_a and the port does not exist.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_op, req_a, req_b         request opcode and operands
//   req_chain                    (ALU_SEQ_CHAIN_EN only) chain operand A
//   alu_opcode, alu_a, alu_b     registered drive to the external ALU
//   alu_out, alu_cy, alu_zero    results from the external ALU
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_cy, rsp_zero   captured result and flags
//   busy                         1 in any state other than IDLE
//   op_count                     completed responses, wraps 255 -> 0
//   state_dbg                    current FSM state (0=IDLE, 1=ISSUE, 2=RESP)

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             req_chain,
`endif
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cy,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cy,
  output logic             rsp_zero,
  output logic             busy,
  output logic [7:0]       op_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_n;

  logic accept;   // request taken this edge
  logic capture;  // ALU result sampled this edge
  logic done;     // response taken this edge

  logic [WIDTH-1:0] a_sel;

`ifdef ALU_SEQ_CHAIN_EN
  // rsp_data resets to 0, so a chained op right after reset sees A=0.
  assign a_sel = req_chain ? rsp_data : req_a;
`else
  assign a_sel = req_a;
`endif

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // ALU drive has been stable for this whole cycle; sample its result.
        capture = 1'b1;
        state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp_cy     <= 1'b0;
      rsp_zero   <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        alu_opcode <= req_op;
        alu_a      <= a_sel;
        alu_b      <= req_b;
      end
      if (capture) begin
        rsp_data <= alu_out;
        rsp_cy   <= alu_cy;
        rsp_zero <= alu_zero;
      end
      if (done) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed bench for alu_seq with a small behavioural ALU
// attached to the alu_* ports.
// Model ALU: 0 add, 1 sub (cy=borrow), 2 and, 3 or, 4 xor, 5 pass A,
// 6 pass B, 7 A<<B[2:0] (cy = bit shifted past the MSB).

module tb_alu_seq;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic             req_chain;
`endif
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cy;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cy;
  logic             rsp_zero;
  logic             busy;
  logic [7:0]       op_count;
  logic [1:0]       state_dbg;

  int total;
  int bad;
  logic [7:0] exp_count;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ALU_SEQ_CHAIN_EN
    .req_chain  (req_chain),
`endif
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_cy     (alu_cy),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cy     (rsp_cy),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .op_count   (op_count),
    .state_dbg  (state_dbg)
  );

  // behavioural ALU
  logic [WIDTH:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (alu_opcode)
      3'd0: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_r = {1'b0, alu_a & alu_b};
      3'd3: alu_r = {1'b0, alu_a | alu_b};
      3'd4: alu_r = {1'b0, alu_a ^ alu_b};
      3'd5: alu_r = {1'b0, alu_a};
      3'd6: alu_r = {1'b0, alu_b};
      default: alu_r = {1'b0, alu_a} << alu_b[2:0];
    endcase
  end
  assign alu_out  = alu_r[WIDTH-1:0];
  assign alu_cy   = alu_r[WIDTH];
  assign alu_zero = (alu_r[WIDTH-1:0] == '0);

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    req_chain = 1'b0;
`endif
  endtask

  // One full transaction: accept, check ALU drive, check response at
  // acceptance+2, then take it and check op_count.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic chain,
                        input logic [7:0] exp_alu_a, input logic [7:0] exp_data,
                        input logic exp_cy, input logic exp_zero,
                        input string name);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
`ifdef ALU_SEQ_CHAIN_EN
    req_chain = chain;
`else
    if (chain) $display("note: chain requested but feature not built");
`endif
    step();  // acceptance edge N
    idle_inputs();
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_issue: busy=%b req_ready=%b rsp_valid=%b, wanted 1 0 0",
               name, busy, req_ready, rsp_valid);
    end
    total++;
    if (alu_opcode !== op || alu_a !== exp_alu_a || alu_b !== b) begin
      bad++;
      $display("FAIL %s_drive: op=%h a=%h b=%h, wanted op=%h a=%h b=%h",
               name, alu_opcode, alu_a, alu_b, op, exp_alu_a, b);
    end
    step();  // edge N+1: result captured, valid seen at N+2
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_cy !== exp_cy ||
        rsp_zero !== exp_zero) begin
      bad++;
      $display("FAIL %s_rsp: valid=%b data=%h cy=%b z=%b, wanted 1 %h %b %b",
               name, rsp_valid, rsp_data, rsp_cy, rsp_zero, exp_data, exp_cy, exp_zero);
    end
    rsp_ready = 1'b1;
    step();  // edge N+2: handshake
    rsp_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== exp_count ||
        rsp_data !== exp_data) begin
      bad++;
      $display("FAIL %s_done: valid=%b busy=%b count=%0d data=%h, wanted 0 0 %0d %h",
               name, rsp_valid, busy, op_count, rsp_data, exp_count, exp_data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        op_count !== 8'd0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b count=%0d st=%0d, wanted 1 0 0 0 0",
               req_ready, rsp_valid, busy, op_count, state_dbg);
    end
    total++;
    if (alu_opcode !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 ||
        rsp_data !== 8'd0 || rsp_cy !== 1'b0 || rsp_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: op=%h a=%h b=%h d=%h cy=%b z=%b, wanted all 0",
               alu_opcode, alu_a, alu_b, rsp_data, rsp_cy, rsp_zero);
    end
    rst_n = 1'b1;
    exp_count = 8'd0;
    step();
  endtask

  task automatic test_ops();
    run_op(3'd0, 8'hF0, 8'h20, 1'b0, 8'hF0, 8'h10, 1'b1, 1'b0, "add");
    run_op(3'd1, 8'h05, 8'h05, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, "sub_eq");
    run_op(3'd1, 8'h03, 8'h05, 1'b0, 8'h03, 8'hFE, 1'b1, 1'b0, "sub_neg");
    run_op(3'd2, 8'hC3, 8'h5A, 1'b0, 8'hC3, 8'h42, 1'b0, 1'b0, "and");
    run_op(3'd6, 8'h11, 8'h00, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1, "passb");
  endtask

  task automatic test_idle_ready();
    // rsp_ready without a response must not count anything
    rsp_ready = 1'b1;
    step();
    step();
    step();
    rsp_ready = 1'b0;
    total++;
    if (op_count !== exp_count || busy !== 1'b0 || rsp_data !== 8'h00 ||
        rsp_zero !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: count=%0d busy=%b d=%h z=%b, wanted %0d 0 00 1",
               op_count, busy, rsp_data, rsp_zero, exp_count);
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 8'h0F;
    req_b     = 8'hFF;
    step();  // accept
    idle_inputs();
    step();  // RESP
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 8'h77;
        req_b     = 8'h01;
      end
      step();
      req_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_cy !== 1'b0 ||
          rsp_zero !== 1'b0 || req_ready !== 1'b0 || op_count !== exp_count ||
          alu_a !== 8'h0F || alu_opcode !== 3'd4) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%b d=%h cy=%b z=%b rdy=%b cnt=%0d a=%h op=%h, wanted 1 f0 0 0 0 %0d 0f 4",
                 i, rsp_valid, rsp_data, rsp_cy, rsp_zero, req_ready, op_count,
                 alu_a, alu_opcode, exp_count);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    total++;
    if (op_count !== exp_count || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: count=%0d valid=%b busy=%b, wanted %0d 0 0",
               op_count, rsp_valid, busy, exp_count);
    end
    step();
    step();
    // the ignored pulse must not have been queued
    total++;
    if (busy !== 1'b0 || op_count !== exp_count || alu_a !== 8'h0F) begin
      bad++;
      $display("FAIL bp_not_queued: busy=%b count=%0d a=%h, wanted 0 %0d 0f",
               busy, op_count, alu_a, exp_count);
    end
  endtask

  task automatic test_reset_midop();
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_a     = 8'h12;
    req_b     = 8'h34;
    step();  // accept, now ISSUE
    idle_inputs();
    total++;
    if (state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL midop_issue: state=%0d, wanted 1", state_dbg);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = 8'd0;
    total++;
    if (state_dbg !== 2'd0 || rsp_valid !== 1'b0 || op_count !== 8'd0 ||
        req_ready !== 1'b1 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL midop_reset: st=%0d valid=%b count=%0d rdy=%b d=%h, wanted 0 0 0 1 00",
               state_dbg, rsp_valid, op_count, req_ready, rsp_data);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd0) begin
        bad++;
        $display("FAIL midop_norsp%0d: valid=%b count=%0d, wanted 0 0",
                 i, rsp_valid, op_count);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 8'h01;
    req_b     = 8'h01;
    rsp_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      step();
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_accept%0d: busy=%b, wanted 1", k, busy);
      end
      step();
      step();
      if (k == 255) req_valid = 1'b0;
      exp_count = exp_count + 8'd1;
      total++;
      if (op_count !== exp_count || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_count%0d: count=%0d busy=%b, wanted %0d 0",
                 k, op_count, busy, exp_count);
      end
    end
    idle_inputs();
    step();
    total++;
    if (op_count !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_zero: count=%0d busy=%b, wanted 0 0", op_count, busy);
    end
  endtask

`ifdef ALU_SEQ_CHAIN_EN
  task automatic test_chain();
    run_op(3'd0, 8'h01, 8'h01, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0, "chain_seed");
    run_op(3'd7, 8'hFF, 8'h01, 1'b1, 8'h02, 8'h04, 1'b0, 1'b0, "chain_use");
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    exp_count = 8'd0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_ops();
    test_idle_ready();
    test_backpressure();
    test_reset_midop();
    test_back_to_back_wrap();
`ifdef ALU_SEQ_CHAIN_EN
    test_chain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
